demux_4_buf: RTL and testbench
==============================

// Module: demux_4_buf
// PURPOSE
// - 1-to-4 routing counterpart of the 4:1 select mux: one producer stream in, one of four consumer streams out.
// - Routes each word by a 2-bit select, e.g. writeback results or LI/LUI immediates sent to one of four destinations.
// - Each output channel has its own 2-entry FIFO, so backpressure on one channel does not stall the others
//   unless the incoming word is routed to that channel.
// - Per-channel accepted-word counters are provided for debug and verification.
// PARAMETERS
// - DATA_WIDTH  32  width of every data path
// - CNT_WIDTH    8  width of each per-channel accepted-word counter; wraps modulo 2^CNT_WIDTH
// PORTS
// - clk        in   1             single clock; all state changes on rising edge
// - rst_n      in   1             asynchronous, active-low reset
// - in_valid   in   1             producer has a word on in_data/in_sel
// - in_ready   out  1             demux can accept the word this cycle
// - in_data    in   DATA_WIDTH    word to route
// - in_sel     in   2             destination channel 0..3
// - out_valid  out  4             bit k: channel k FIFO non-empty
// - out_ready  in   4             bit k: consumer k takes the head word this cycle
// - out_data0  out  DATA_WIDTH    head of channel 0 FIFO
// - out_data1  out  DATA_WIDTH    head of channel 1 FIFO
// - out_data2  out  DATA_WIDTH    head of channel 2 FIFO
// - out_data3  out  DATA_WIDTH    head of channel 3 FIFO
// - cnt0..cnt3 out  CNT_WIDTH     words accepted into channel k since reset
// BEHAVIOUR
// - Reset (rst_n=0, async):
//   - all FIFOs empty; out_valid=4'b0000; cnt0..cnt3=0; out_data0..3=0.
//   - in_ready is low while rst_n=0.
// - Handshake:
//   - input transfer when in_valid & in_ready at a rising edge.
//   - output k transfer when out_valid[k] & out_ready[k] at a rising edge.
//   - in_data and in_sel are sampled only on a transfer.
// - in_ready (combinational):
//   - in_ready = rst_n & ~full[in_sel]; it depends on in_sel, not on in_valid.
//   - no same-cycle bypass: a full channel deasserts in_ready even if out_ready[in_sel]=1.
// - Per-channel FIFO (depth 2):
//   - registers: two entries, 1-bit write pointer, 1-bit read pointer, 2-bit occupancy.
//   - empty = (occ==0); full = (occ==2).
//   - push only, no pop: occ+1.
//   - pop only, no push: occ-1.
//   - push and pop on the same channel in the same cycle (only possible when occ==1):
//     occ stays 1; head becomes the new word at the next edge.
//   - pointers wrap 1 -> 0.
//   - out_dataK is the entry at the read pointer (registered, not combinational from in_data).
//   - out_dataK holds its last value while empty; consumers must qualify it with out_valid.
// - Latency:
//   - word accepted at edge N is visible as out_valid[k]=1 from edge N (after the update) into cycle N+1.
//   - i.e. 1 cycle input-to-output when the channel is empty.
//   - a pop at edge M exposes the next entry (if any) immediately after edge M.
// - Independence:
//   - pops on any subset of channels and one push to any channel may all occur in the same cycle.
//   - channels never affect each other's state.
// - Ordering: words to the same channel leave in acceptance order; no ordering across channels.
// - Counters:
//   - cntK increments by 1 on every accepted word with in_sel==K.
//   - wraps from 2^CNT_WIDTH-1 to 0 with no flag.
//   - counters do not decrement on pop.
// - Reset mid-operation:
//   - rst_n falling clears all FIFOs and counters immediately; words in flight are discarded.
//   - resumes accepting on the first rising edge after rst_n returns high.
// - Illegal/undefined: none; every in_sel value is a valid channel.
// TESTING
// - Reset: hold rst_n=0 with in_valid=1 -> in_ready=0, out_valid=0000, cnt0..3=0; release -> in_ready=1.
// - Routing: send 0xA0,0xA1,0xA2,0xA3 with sel 0,1,2,3 and all out_ready=1
//   -> each appears on out_dataK one cycle later; cnt0..3=1 each.
// - Full/backpressure: out_ready[2]=0, send 3 words sel=2
//   -> after 2 accepts out_valid[2]=1 and in_ready=0 for sel=2;
//   -> in_ready=1 for sel=0 (word to channel 0 is accepted meanwhile);
//   -> raising out_ready[2] drains 0x..1, 0x..2 in order, then the 3rd word is accepted.
// - Simultaneous push/pop: channel 1 holding one word, push 0x55 sel=1 while out_ready[1]=1
//   -> occupancy stays 1; out_data1=0x55 next cycle.
// - Counter wrap: CNT_WIDTH=8, accept 256 words to channel 3 -> cnt3 returns to 0; 257th word -> cnt3=1.
// - Reset mid-operation: two channels holding words, pulse rst_n low between edges
//   -> out_valid=0000 and counters=0 immediately; no stale words after release.

Source files
------------

// File: rtl/demux_4_buf.sv
// demux_4_buf: routes one producer stream to one of four consumer streams.
// Each output channel has its own 2-entry FIFO, so a stalled consumer only
// blocks words that are routed to it. Per-channel counters record how many
// words each channel has accepted since reset.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready depends on rst_n and in_sel only, never on
// in_valid; out_valid[k] depends only on channel k's occupancy.
module demux_4_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_sel,
    output logic [3:0]            out_valid,
    input  logic [3:0]            out_ready,
    output logic [DATA_WIDTH-1:0] out_data0,
    output logic [DATA_WIDTH-1:0] out_data1,
    output logic [DATA_WIDTH-1:0] out_data2,
    output logic [DATA_WIDTH-1:0] out_data3,
    output logic [CNT_WIDTH-1:0]  cnt0,
    output logic [CNT_WIDTH-1:0]  cnt1,
    output logic [CNT_WIDTH-1:0]  cnt2,
    output logic [CNT_WIDTH-1:0]  cnt3
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Per-channel FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0] mem_q  [4][2];
    logic [DATA_WIDTH-1:0] mem_d  [4][2];
    logic [3:0]            wr_ptr_q, wr_ptr_d;
    logic [3:0]            rd_ptr_q, rd_ptr_d;
    logic [1:0]            occ_q  [4];
    logic [1:0]            occ_d  [4];
    // Registered head word; holds its last value when the channel drains
    logic [DATA_WIDTH-1:0] head_q [4];
    logic [DATA_WIDTH-1:0] head_d [4];
    logic [CNT_WIDTH-1:0]  cnt_q  [4];
    logic [CNT_WIDTH-1:0]  cnt_d  [4];

    logic [3:0] full;
    logic [3:0] push;
    logic [3:0] pop;

    // Status flags, input readiness and per-channel push/pop strobes
    always_comb begin
        full      = 4'b0000;
        out_valid = 4'b0000;
        push      = 4'b0000;
        pop       = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            full[k]      = (occ_q[k] == 2'd2);
            out_valid[k] = (occ_q[k] != 2'd0);
        end
        // No bypass: a full channel is not ready even if its consumer pops now.
        in_ready = rst_n & ~full[in_sel];
        for (int k = 0; k < 4; k++) begin
            push[k] = in_valid & in_ready & (in_sel == 2'(k));
            pop[k]  = out_valid[k] & out_ready[k];
        end
    end

    // Next-state for each channel's FIFO, head register and counter
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        head_d   = head_q;
        cnt_d    = cnt_q;
        for (int k = 0; k < 4; k++) begin
            if (push[k]) begin
                mem_d[k][wr_ptr_q[k]] = in_data;
                wr_ptr_d[k]           = ~wr_ptr_q[k];
                cnt_d[k]              = cnt_q[k] + CNT_ONE;
            end
            if (pop[k]) begin
                rd_ptr_d[k] = ~rd_ptr_q[k];
            end
            case ({push[k], pop[k]})
                2'b10:   occ_d[k] = occ_q[k] + 2'd1;
                2'b01:   occ_d[k] = occ_q[k] - 2'd1;
                default: occ_d[k] = occ_q[k];
            endcase
            // Push+pop at occupancy 1 lands the new word at the new read slot,
            // so the head picks it up from mem_d in the same edge.
            if (occ_d[k] != 2'd0) begin
                head_d[k] = mem_d[k][rd_ptr_d[k]];
            end
        end
    end

    // State registers, cleared asynchronously by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 4'b0000;
            rd_ptr_q <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                mem_q[k][0] <= '0;
                mem_q[k][1] <= '0;
                occ_q[k]    <= 2'd0;
                head_q[k]   <= '0;
                cnt_q[k]    <= '0;
            end
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            head_q   <= head_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_data0 = head_q[0];
    assign out_data1 = head_q[1];
    assign out_data2 = head_q[2];
    assign out_data3 = head_q[3];
    assign cnt0      = cnt_q[0];
    assign cnt1      = cnt_q[1];
    assign cnt2      = cnt_q[2];
    assign cnt3      = cnt_q[3];

endmodule

// File: tb/tb_demux_4_buf.sv
// Bench for demux_4_buf: per-channel queue model, a negedge compare process,
// and directed scenarios with hand-computed literal expectations.
module tb_demux_4_buf;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data0, out_data1, out_data2, out_data3;
    logic [7:0]  cnt0, cnt1, cnt2, cnt3;

    int checks = 0;
    int errors = 0;

    demux_4_buf #(.DATA_WIDTH(32), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1),
        .out_data2(out_data2), .out_data3(out_data3),
        .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
    );

    logic [31:0] od [4];
    logic [7:0]  cn [4];
    assign od[0] = out_data0;
    assign od[1] = out_data1;
    assign od[2] = out_data2;
    assign od[3] = out_data3;
    assign cn[0] = cnt0;
    assign cn[1] = cnt1;
    assign cn[2] = cnt2;
    assign cn[3] = cnt3;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model: one FIFO queue per channel ----------------
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    logic [31:0] exp_q2[$];
    logic [31:0] exp_q3[$];
    int          cnt_m [4] = '{0, 0, 0, 0};

    function automatic int msize(input int k);
        case (k)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            2:       return exp_q2.size();
            default: return exp_q3.size();
        endcase
    endfunction

    function automatic logic [31:0] mfront(input int k);
        case (k)
            0:       return exp_q0[0];
            1:       return exp_q1[0];
            2:       return exp_q2[0];
            default: return exp_q3[0];
        endcase
    endfunction

    task automatic mpush(input int k, input logic [31:0] d);
        case (k)
            0:       exp_q0.push_back(d);
            1:       exp_q1.push_back(d);
            2:       exp_q2.push_back(d);
            default: exp_q3.push_back(d);
        endcase
    endtask

    task automatic mpop(input int k);
        logic [31:0] dummy;
        case (k)
            0:       dummy = exp_q0.pop_front();
            1:       dummy = exp_q1.pop_front();
            2:       dummy = exp_q2.pop_front();
            default: dummy = exp_q3.pop_front();
        endcase
    endtask

    // Model step: capacity 2 per channel, no bypass, counters modulo 256.
    always @(posedge clk) begin
        if (rst_n) begin
            bit accept;
            accept = in_valid && (msize(int'(in_sel)) < 2);
            for (int k = 0; k < 4; k++)
                if (msize(k) > 0 && out_ready[k]) mpop(k);
            if (accept) begin
                mpush(int'(in_sel), in_data);
                cnt_m[in_sel] = (cnt_m[in_sel] + 1) % 256;
            end
        end
    end

    always @(negedge rst_n) begin
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
        exp_q3.delete();
        for (int k = 0; k < 4; k++) cnt_m[k] = 0;
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        check("cmp_in_ready", 32'(in_ready), 32'(rst_n && (msize(int'(in_sel)) < 2)));
        for (int k = 0; k < 4; k++) begin
            check($sformatf("cmp_out_valid%0d", k), 32'(out_valid[k]), 32'(msize(k) > 0));
            check($sformatf("cmp_cnt%0d", k), 32'(cn[k]), 32'(cnt_m[k]));
            if (msize(k) > 0)
                check($sformatf("cmp_out_data%0d", k), od[k], mfront(k));
        end
    end

    // ---------------- driver ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        in_data   = 32'h0;
        out_ready = 4'b0000;

        // Reset with in_valid high
        repeat (3) @(posedge clk);
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_cnt", {cnt3, cnt2, cnt1, cnt0}, 32'd0);
        check("rst_out_data0", out_data0, 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // Routing to all four channels, consumers always ready
        out_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_sel   = 2'(i);
            in_data  = 32'hA0 + 32'(i);
            cyc();
            check("route_valid", 32'(out_valid[i]), 32'd1);
            check("route_data", od[i], 32'hA0 + 32'(i));
        end
        in_valid = 1'b0;
        cyc();
        check("route_cnt", {cnt3, cnt2, cnt1, cnt0}, 32'h01010101);
        check("route_drained", 32'(out_valid), 32'd0);

        // Backpressure on channel 2
        out_ready = 4'b1011;
        in_valid  = 1'b1;
        in_sel    = 2'd2;
        in_data   = 32'hB1;
        cyc();
        in_data = 32'hB2;
        cyc();
        in_data = 32'hB3;
        #1;
        check("bp_full_ready", 32'(in_ready), 32'd0);
        check("bp_valid2", 32'(out_valid[2]), 32'd1);
        check("bp_head2", out_data2, 32'hB1);
        cyc();
        check("bp_cnt2_held", 32'(cnt2), 32'd3);
        in_sel  = 2'd0;
        in_data = 32'hC0;
        #1;
        check("bp_other_ready", 32'(in_ready), 32'd1);
        cyc();
        check("bp_cnt0", 32'(cnt0), 32'd2);
        in_sel    = 2'd2;
        in_data   = 32'hB3;
        out_ready = 4'hF;
        cyc();
        check("bp_drain1", out_data2, 32'hB2);
        check("bp_cnt2_mid", 32'(cnt2), 32'd3);
        cyc();
        check("bp_drain2", out_data2, 32'hB3);
        check("bp_cnt2_end", 32'(cnt2), 32'd4);
        in_valid = 1'b0;
        cyc();
        check("bp_empty", 32'(out_valid), 32'd0);

        // Simultaneous push and pop on channel 1
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        in_data   = 32'h44;
        cyc();
        check("pp_first", out_data1, 32'h44);
        out_ready = 4'b0010;
        in_data   = 32'h55;
        cyc();
        check("pp_valid", 32'(out_valid), 32'b0010);
        check("pp_head", out_data1, 32'h55);
        in_valid  = 1'b0;
        out_ready = 4'hF;
        cyc();
        check("pp_empty", 32'(out_valid), 32'd0);

        // Counter wrap on channel 3 (starts at 1)
        in_valid = 1'b1;
        in_sel   = 2'd3;
        for (int i = 0; i < 255; i++) begin
            in_data = $urandom;
            cyc();
        end
        check("wrap_zero", 32'(cnt3), 32'd0);
        in_data = 32'h1234;
        cyc();
        check("wrap_one", 32'(cnt3), 32'd1);
        check("wrap_data", out_data3, 32'h1234);
        in_valid = 1'b0;
        cyc();

        // Reset pulse mid-operation with two channels loaded
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        in_data   = 32'h11;
        cyc();
        in_sel  = 2'd1;
        in_data = 32'h22;
        cyc();
        in_valid = 1'b0;
        check("mr_loaded", 32'(out_valid), 32'b0011);
        rst_n = 1'b0;
        #1;
        check("mr_valid", 32'(out_valid), 32'd0);
        check("mr_cnt", {cnt3, cnt2, cnt1, cnt0}, 32'd0);
        check("mr_ready", 32'(in_ready), 32'd0);
        #1;
        rst_n = 1'b1;
        cyc();
        cyc();
        check("mr_no_stale", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        in_sel   = 2'd1;
        in_data  = 32'h77;
        cyc();
        check("mr_resume_data", out_data1, 32'h77);
        check("mr_resume_valid", 32'(out_valid), 32'b0010);
        check("mr_resume_cnt", {cnt3, cnt2, cnt1, cnt0}, 32'h00000100);
        in_valid  = 1'b0;
        out_ready = 4'hF;
        cyc();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
